// File: rtl/alu_exec_pkg.sv
// ============================================================================
// Module      : alu_defs (package)
// Description : ALU control codes shared with the control decoder, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_defs;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  function automatic logic is_multicycle(input logic [2:0] ctrl);
    return (ctrl == ALU_MUL);
  endfunction

endpackage : alu_defs

`default_nettype wire

// File: rtl/alu_exec_if.sv
// ============================================================================
// Module      : alu_exec_if
// Description : Request/result bundle between the pipeline and alu_exec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_exec_if #(
  parameter int WIDTH = 32
) ();

  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  busy_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output busy_o, valid_o, data_o, zero_o
  );

endinterface : alu_exec_if

`default_nettype wire

// File: rtl/alu_exec_mul_iter.sv
// ============================================================================
// Module      : mul_iter
// Description : Iterative shift-add multiplier, one partial product per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_iter #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  input  wire logic             start_i,
  input  wire logic             step_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [WIDTH-1:0]      product_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] partial_w;
  logic [WIDTH-1:0] acc_d;

  assign partial_w = mplier_q[0] ? mcand_q : '0;
  assign acc_d     = acc_q + partial_w;

  // Product is the accumulator after the current step, so the final
  // iteration's sum is visible on the same edge that reports done.
  assign done_o    = step_i && (count_q == '0);
  assign product_o = acc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      count_q  <= CW'(WIDTH - 1);
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (count_q != '0) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule : mul_iter

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module      : alu_exec
// Description : Execution-stage ALU; single-cycle ops plus iterative multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  alu_exec_if.slave  bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             zero_q,  zero_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res_w;
  logic             mul_start_w;
  logic             mul_step_w;
  logic             mul_done_w;
  logic [WIDTH-1:0] mul_prod_w;

  always_comb begin
    alu_res_w = '0;
    case (bus.ALUCtrl_i)
      ALU_ADD: alu_res_w = bus.data1_i + bus.data2_i;
      ALU_SUB: alu_res_w = bus.data1_i - bus.data2_i;
      ALU_AND: alu_res_w = bus.data1_i & bus.data2_i;
      ALU_OR:  alu_res_w = bus.data1_i | bus.data2_i;
      ALU_SLT: alu_res_w = {{(WIDTH-1){1'b0}},
                            ($signed(bus.data1_i) < $signed(bus.data2_i))};
      default: alu_res_w = '0;
    endcase
  end

  assign mul_step_w = (state_q == ST_MUL);

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start_w),
    .step_i    (mul_step_w),
    .a_i       (bus.data1_i),
    .b_i       (bus.data2_i),
    .done_o    (mul_done_w),
    .product_o (mul_prod_w)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    zero_d      = zero_q;
    valid_d     = 1'b0;
    mul_start_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          if (is_multicycle(bus.ALUCtrl_i)) begin
            mul_start_w = 1'b1;
            state_d     = ST_MUL;
          end else begin
            data_d  = alu_res_w;
            zero_d  = (alu_res_w == '0);
            valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // Requests presented while multiplying are ignored, not queued.
        if (mul_done_w) begin
          data_d  = mul_prod_w;
          zero_d  = (mul_prod_w == '0);
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy_o  = (state_q == ST_MUL);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.zero_o  = zero_q;

endmodule : alu_exec

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module      : tb_alu_exec
// Description : Directed and randomized checks of alu_exec against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec;
  import alu_defs::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  alu_exec_if #(.WIDTH(32)) bus ();

  alu_exec #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] full;
    case (c)
      3'b010: return a + b;
      3'b110: return a - b;
      3'b000: return a & b;
      3'b001: return a | b;
      3'b011: begin
        full = {32'd0, a} * {32'd0, b};
        return full[31:0];
      end
      3'b111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one request and checks its result; expects the DUT idle on entry.
  task automatic run_op(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int n;
    exp           = ref_alu(c, a, b);
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = c;
    bus.data1_i   = a;
    bus.data2_i   = b;
    tick();
    bus.valid_i   = 1'b0;
    bus.data1_i   = $urandom;
    bus.data2_i   = $urandom;
    if (c == ALU_MUL) begin
      chk({tag, "_busy_start"}, {31'd0, bus.busy_o}, 32'd1);
      n = 0;
      while (bus.busy_o && n < 100) begin
        tick();
        n++;
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
    end
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd1);
    chk({tag, "_data"}, bus.data_o, exp);
    chk({tag, "_zero"}, {31'd0, bus.zero_o}, {31'd0, exp == 32'd0});
    tick();
    chk({tag, "_valid_drop"}, {31'd0, bus.valid_o}, 32'd0);
    chk({tag, "_data_hold"}, bus.data_o, exp);
  endtask

  initial begin
    logic [31:0] a, b, exp_mul;
    logic [2:0]  c;
    int n;

    bus.valid_i   = 1'b0;
    bus.ALUCtrl_i = 3'b000;
    bus.data1_i   = '0;
    bus.data2_i   = '0;

    rst_i = 1'b0;
    repeat (3) tick();
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_zero", {31'd0, bus.zero_o}, 32'd1);
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    chk("idle_valid", {31'd0, bus.valid_o}, 32'd0);

    run_op(ALU_ADD, 32'd5, 32'd7, "add_5_7");
    run_op(ALU_SUB, 32'd7, 32'd7, "sub_7_7");
    run_op(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, "and");
    run_op(ALU_OR,  32'h0000_F0F0, 32'h0000_0FF0, "or");
    run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, "slt_neg");
    run_op(ALU_SLT, 32'd1, 32'hFFFF_FFFF, "slt_pos");
    run_op(3'b100, 32'd9, 32'd3, "undef4");
    run_op(3'b101, 32'd9, 32'd3, "undef5");
    run_op(ALU_MUL, 32'd6, 32'd7, "mul_6_7");
    run_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, "mul_neg1_2");
    run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0000, "mul_wrap");

    for (int i = 0; i < 24; i++) begin
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      run_op(c, a, b, "rand");
    end

    // Held request during a multiply: must be ignored until the FSM is idle.
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = 32'd1234;
    bus.data2_i   = 32'd5678;
    exp_mul       = ref_alu(ALU_MUL, 32'd1234, 32'd5678);
    tick();
    n = 0;
    while (bus.busy_o && n < 100) begin
      bus.ALUCtrl_i = 3'($urandom_range(0, 7));
      bus.data1_i   = $urandom;
      bus.data2_i   = $urandom;
      tick();
      n++;
    end
    bus.ALUCtrl_i = ALU_ADD;
    bus.data1_i   = 32'd100;
    bus.data2_i   = 32'd23;
    chk("hold_busy_cycles", 32'(n), 32'd32);
    chk("hold_mul_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("hold_mul_data", bus.data_o, exp_mul);
    tick();
    bus.valid_i = 1'b0;
    chk("hold_add_valid", {31'd0, bus.valid_o}, 32'd1);
    chk("hold_add_data", bus.data_o, 32'd123);
    tick();
    chk("hold_add_drop", {31'd0, bus.valid_o}, 32'd0);

    // Reset in the middle of a multiply aborts it.
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = ALU_MUL;
    bus.data1_i   = 32'h0000_FFFF;
    bus.data2_i   = 32'h0000_1234;
    tick();
    bus.valid_i = 1'b0;
    repeat (10) tick();
    chk("abort_busy_before", {31'd0, bus.busy_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("abort_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("abort_data", bus.data_o, 32'd0);
    chk("abort_zero", {31'd0, bus.zero_o}, 32'd1);
    tick();
    #2 rst_i = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_o || bus.busy_o) n++;
    end
    chk("abort_quiet", 32'(n), 32'd0);
    run_op(ALU_ADD, 32'd1, 32'd1, "post_abort_add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_exec

`default_nettype wire
